// File: rtl/dmem_lsu.sv
// Load/store unit: bridges datapath memory outputs onto a request/grant bus,
// stalling the core until the access completes, with lane steering, load extension and timeout.
module dmem_lsu #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        MisAlign,
    output logic        BusErr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam logic [16:0] TIMEOUT_CNT = 17'(TIMEOUT);

    state_t      state_reg;
    logic [29:0] addr_reg;
    logic [1:0]  off_reg;
    logic [3:0]  be_reg;
    logic [31:0] wdata_reg;
    logic        we_reg;
    logic [2:0]  funct3_reg;
    logic [15:0] cnt_reg;
    logic [31:0] rdata_reg;
    logic        err_reg;

    logic        access;
    logic        is_byte;
    logic        is_half;
    logic        misaligned;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_data;
    logic [16:0] cnt_inc;
    logic        timeout_hit;

    // Size decode: unsigned byte/half codes only exist for loads; everything else is a word.
    always_comb begin
        access   = MemRead | MemWrite;
        is_byte  = (funct3 == 3'b000) || (!MemWrite && funct3 == 3'b100);
        is_half  = (funct3 == 3'b001) || (!MemWrite && funct3 == 3'b101);
        if (is_byte) begin
            misaligned = 1'b0;
            be_next    = 4'b0001 << ALUResult[1:0];
            wdata_next = {4{WriteData[7:0]}};
        end else if (is_half) begin
            misaligned = ALUResult[0];
            be_next    = 4'b0011 << ALUResult[1:0];
            wdata_next = {2{WriteData[15:0]}};
        end else begin
            misaligned = (ALUResult[1:0] != 2'b00);
            be_next    = 4'b1111;
            wdata_next = WriteData;
        end
        if (!MemWrite) begin
            wdata_next = 32'h0;
        end
    end

    always_comb begin
        sel_byte = mem_rdata[{off_reg, 3'b000} +: 8];
        sel_half = off_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_reg)
            3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
            3'b100:  load_data = {24'h0, sel_byte};
            3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
            3'b101:  load_data = {16'h0, sel_half};
            default: load_data = mem_rdata;
        endcase
    end

    assign cnt_inc     = {1'b0, cnt_reg} + 17'd1;
    assign timeout_hit = (cnt_inc == TIMEOUT_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            addr_reg   <= '0;
            off_reg    <= '0;
            be_reg     <= '0;
            wdata_reg  <= '0;
            we_reg     <= 1'b0;
            funct3_reg <= '0;
            cnt_reg    <= '0;
            rdata_reg  <= '0;
            err_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (access && !misaligned) begin
                        state_reg  <= REQ;
                        addr_reg   <= ALUResult[31:2];
                        off_reg    <= ALUResult[1:0];
                        be_reg     <= be_next;
                        wdata_reg  <= wdata_next;
                        we_reg     <= MemWrite;
                        funct3_reg <= funct3;
                        cnt_reg    <= '0;
                        rdata_reg  <= '0;
                        err_reg    <= 1'b0;
                    end
                end
                REQ: begin
                    cnt_reg <= cnt_inc[15:0];
                    // A completing handshake wins over an expiring budget in the same cycle.
                    if (mem_gnt && we_reg) begin
                        state_reg <= DONE;
                    end else if (mem_gnt && mem_rvalid) begin
                        rdata_reg <= load_data;
                        state_reg <= DONE;
                    end else if (timeout_hit) begin
                        err_reg   <= 1'b1;
                        state_reg <= DONE;
                    end else if (mem_gnt) begin
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    cnt_reg <= cnt_inc[15:0];
                    if (mem_rvalid) begin
                        rdata_reg <= load_data;
                        state_reg <= DONE;
                    end else if (timeout_hit) begin
                        err_reg   <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Outputs are forced low while reset is held, even though IDLE decodes live inputs.
    always_comb begin
        mem_req   = !rst && (state_reg == REQ);
        mem_we    = mem_req && we_reg;
        mem_addr  = mem_req ? {addr_reg, 2'b00} : 32'h0;
        mem_be    = mem_req ? be_reg : 4'h0;
        mem_wdata = mem_req ? wdata_reg : 32'h0;
        Stall     = !rst && (((state_reg == IDLE) && access && !misaligned)
                              || (state_reg == REQ) || (state_reg == WAIT));
        MisAlign  = !rst && (state_reg == IDLE) && access && misaligned;
        BusErr    = !rst && (state_reg == DONE) && err_reg;
        ReadData  = (!rst && (state_reg == DONE)) ? rdata_reg : 32'h0;
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: vector table with a bus responder, scoreboard of
// expected completions, plus timeout, late-grant and mid-transaction reset sequences.
module tb_dmem_lsu;

    logic        clk;
    logic        rst;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Stall;
    logic        MisAlign;
    logic        BusErr;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    dmem_lsu #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .funct3(funct3),
        .ALUResult(ALUResult), .WriteData(WriteData), .ReadData(ReadData), .Stall(Stall),
        .MisAlign(MisAlign), .BusErr(BusErr), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd_en;
        logic        wr_en;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gnt_lat;
        int          rv_lat;
        logic        exp_mis;
        logic        exp_err;
        logic [31:0] exp_rd;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        int          exp_cycles;
    } vec_t;

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    localparam int NVEC = 18;
    vec_t vecs[NVEC];
    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int   c;
        int   req_n;
        int   wait_n;
        bit   gnt_done;
        bit   req_seen;
        bit   fin;
        exp_t e;
        @(posedge clk);
        #1;
        MemRead   = v.rd_en;
        MemWrite  = v.wr_en;
        funct3    = v.f3;
        ALUResult = v.addr;
        WriteData = v.wdata;
        sb_q.push_back('{rd: v.exp_rd, err: v.exp_err});
        req_n = 0; wait_n = 0; gnt_done = 0; req_seen = 0; fin = 0;
        for (c = 1; c <= 40 && !fin; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check($sformatf("v%0d_stall_first", idx), 32'(Stall), 32'(!v.exp_mis));
                check($sformatf("v%0d_misalign", idx), 32'(MisAlign), 32'(v.exp_mis));
            end
            if (v.exp_mis || (c > 1 && !Stall)) begin
                fin = 1;
                mem_gnt = 1'b0; mem_rvalid = 1'b0;
                check($sformatf("v%0d_cycles", idx), 32'(c), 32'(v.exp_cycles));
                check($sformatf("v%0d_req_done", idx), 32'(mem_req), 32'd0);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check($sformatf("v%0d_readdata", idx), ReadData, e.rd);
                    check($sformatf("v%0d_buserr", idx), 32'(BusErr), 32'(e.err));
                end else begin
                    check($sformatf("v%0d_sb_underflow", idx), 32'(sb_q.size()), 32'd1);
                end
                $display("vec %0d: addr=%h f3=%b we=%b cycles=%0d rd=%h err=%b mis=%b",
                         idx, v.addr, v.f3, v.wr_en, c, ReadData, BusErr, MisAlign);
            end else begin
                if (mem_req && !req_seen) begin
                    req_seen = 1;
                    check($sformatf("v%0d_addr", idx), mem_addr, v.exp_addr);
                    check($sformatf("v%0d_be", idx), 32'(mem_be), 32'(v.exp_be));
                    check($sformatf("v%0d_we", idx), 32'(mem_we), 32'(v.wr_en));
                    if (v.wr_en)
                        check($sformatf("v%0d_wdata", idx), mem_wdata, v.exp_wdata);
                end
                mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h5555_5555;
                if (mem_req) begin
                    if (req_n == v.gnt_lat) begin
                        mem_gnt  = 1'b1;
                        gnt_done = 1;
                        if (v.rv_lat == 0) begin
                            mem_rvalid = 1'b1;
                            mem_rdata  = v.rdata;
                        end
                    end else begin
                        mem_rvalid = 1'b1;  // stray rvalid without grant must be ignored
                    end
                    req_n++;
                end else if (gnt_done) begin
                    wait_n++;
                    if (wait_n == v.rv_lat) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = v.rdata;
                    end
                end
            end
        end
        if (!fin) begin
            check($sformatf("v%0d_no_done_in_budget", idx), 32'd0, 32'd1);
            mem_gnt = 1'b0; mem_rvalid = 1'b0;
            void'(sb_q.pop_front());
        end
    endtask

    task automatic late_gnt_check();
        @(posedge clk);
        #1;
        MemRead = 1'b0; MemWrite = 1'b0;
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hA5A5_A5A5;
        @(negedge clk);
        check("late_buserr_cleared", 32'(BusErr), 32'd0);
        check("late_stall", 32'(Stall), 32'd0);
        check("late_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        check("late_req2", 32'(mem_req), 32'd0);
        check("late_readdata", ReadData, 32'h0);
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        $display("late grant after timeout: req=%b stall=%b", mem_req, Stall);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            rd wr  f3      addr          wdata         rdata         g   r  mis err exp_rd        exp_addr      be     exp_wdata     cyc
        vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 0,  1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_0100, 4'hF, 32'h0,         4};
        vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,         32'h80FF_0000, 0,  1, 1'b0, 1'b0, 32'hFFFF_FF80, 32'h0000_0100, 4'h8, 32'h0,         4};
        vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0,         32'h80FF_0000, 0,  0, 1'b0, 1'b0, 32'h0000_0080, 32'h0000_0100, 4'h8, 32'h0,         3};
        vecs[3]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'h0,         0,  0, 1'b0, 1'b0, 32'h0,         32'h0000_0200, 4'hC, 32'hABCD_ABCD, 3};
        vecs[4]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0,         32'h0,         0,  0, 1'b1, 1'b0, 32'h0,         32'h0,         4'h0, 32'h0,         1};
        vecs[5]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0,         32'h8001_7FFF, 1,  0, 1'b0, 1'b0, 32'hFFFF_8001, 32'h0000_0100, 4'hC, 32'h0,         4};
        vecs[6]  = '{1'b1, 1'b0, 3'b101, 32'h0000_0100, 32'h0,         32'h8001_8002, 0,  0, 1'b0, 1'b0, 32'h0000_8002, 32'h0000_0100, 4'h3, 32'h0,         3};
        vecs[7]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0101, 32'h0000_00A5, 32'h0,         2,  0, 1'b0, 1'b0, 32'h0,         32'h0000_0100, 4'h2, 32'hA5A5_A5A5, 5};
        vecs[8]  = '{1'b1, 1'b1, 3'b010, 32'h0000_0030, 32'hCAFE_F00D, 32'h1111_1111, 0,  0, 1'b0, 1'b0, 32'h0,         32'h0000_0030, 4'hF, 32'hCAFE_F00D, 3};
        vecs[9]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0203, 32'h1234_5678, 32'h0,         0,  0, 1'b1, 1'b0, 32'h0,         32'h0,         4'h0, 32'h0,         1};
        vecs[10] = '{1'b1, 1'b0, 3'b101, 32'h0000_0105, 32'h0,         32'h0,         0,  0, 1'b1, 1'b0, 32'h0,         32'h0,         4'h0, 32'h0,         1};
        vecs[11] = '{1'b1, 1'b0, 3'b000, 32'h0000_0101, 32'h0,         32'h0000_7F00, 0,  1, 1'b0, 1'b0, 32'h0000_007F, 32'h0000_0100, 4'h2, 32'h0,         4};
        vecs[12] = '{1'b1, 1'b0, 3'b011, 32'h0000_0010, 32'h0,         32'h1122_3344, 0,  0, 1'b0, 1'b0, 32'h1122_3344, 32'h0000_0010, 4'hF, 32'h0,         3};
        vecs[13] = '{1'b1, 1'b0, 3'b011, 32'h0000_0012, 32'h0,         32'h0,         0,  0, 1'b1, 1'b0, 32'h0,         32'h0,         4'h0, 32'h0,         1};
        vecs[14] = '{1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0,         32'h7777_7777, 99, 0, 1'b0, 1'b1, 32'h0,         32'h0000_0040, 4'hF, 32'h0,         6};
        vecs[15] = '{1'b1, 1'b0, 3'b101, 32'h0000_0042, 32'h0,         32'h7777_7777, 0, 99, 1'b0, 1'b1, 32'h0,         32'h0000_0040, 4'hC, 32'h0,         6};
        vecs[16] = '{1'b0, 1'b1, 3'b110, 32'h0000_0044, 32'h0BAD_CAFE, 32'h0,         0,  0, 1'b0, 1'b0, 32'h0,         32'h0000_0044, 4'hF, 32'h0BAD_CAFE, 3};
        vecs[17] = '{1'b0, 1'b1, 3'b000, 32'h0000_0203, 32'hFFFF_FF7E, 32'h0,         1,  0, 1'b0, 1'b0, 32'h0,         32'h0000_0200, 4'h8, 32'h7E7E_7E7E, 4};

        // Reset held with an aligned load presented: everything must stay low.
        rst = 1'b1;
        MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'b010;
        ALUResult = 32'h0000_0100; WriteData = 32'h0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_stall", 32'(Stall), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_readdata", ReadData, 32'h0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_buserr", 32'(BusErr), 32'd0);
        $display("reset: stall=%b req=%b rd=%h", Stall, mem_req, ReadData);
        @(posedge clk);
        #1;
        rst = 1'b0;
        MemRead = 1'b0;

        // Non-memory instruction with a misaligned-looking address: zero-cycle, silent.
        @(posedge clk);
        #1;
        ALUResult = 32'h0000_0101;
        @(negedge clk);
        check("nomem_stall", 32'(Stall), 32'd0);
        check("nomem_misalign", 32'(MisAlign), 32'd0);
        check("nomem_req", 32'(mem_req), 32'd0);
        check("nomem_readdata", ReadData, 32'h0);
        $display("non-memory instruction: stall=%b misalign=%b", Stall, MisAlign);

        for (int i = 0; i < NVEC; i++) begin
            run_vec(i, vecs[i]);
            if (i == 14) late_gnt_check();
        end

        // Reset asserted between edges while in REQ.
        @(posedge clk);
        #1;
        MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'b010; ALUResult = 32'h0000_0080;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        @(posedge clk);
        #2;
        check("mid_req_req_before", 32'(mem_req), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_req_req_after", 32'(mem_req), 32'd0);
        check("mid_req_stall_after", 32'(Stall), 32'd0);
        check("mid_req_addr_after", mem_addr, 32'h0);
        $display("reset mid-REQ: req=%b stall=%b", mem_req, Stall);
        @(posedge clk);
        #1;
        rst = 1'b0;
        MemRead = 1'b0;

        // Reset asserted between edges while in WAIT.
        @(posedge clk);
        #1;
        MemRead = 1'b1; funct3 = 3'b010; ALUResult = 32'h0000_0084;
        @(posedge clk);
        @(negedge clk);
        mem_gnt = 1'b1;
        @(posedge clk);
        #1;
        mem_gnt = 1'b0;
        #1;
        check("mid_wait_stall_before", 32'(Stall), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_wait_stall_after", 32'(Stall), 32'd0);
        check("mid_wait_req_after", 32'(mem_req), 32'd0);
        check("mid_wait_readdata_after", ReadData, 32'h0);
        $display("reset mid-WAIT: req=%b stall=%b", mem_req, Stall);
        @(posedge clk);
        #1;
        rst = 1'b0;
        MemRead = 1'b0;

        run_vec(100, '{1'b0, 1'b1, 3'b010, 32'h0000_0088, 32'h1357_2468, 32'h0, 0, 0,
                       1'b0, 1'b0, 32'h0, 32'h0000_0088, 4'hF, 32'h1357_2468, 3});

        @(posedge clk);
        #1;
        MemRead = 1'b0; MemWrite = 1'b0;
        check("sb_empty_at_end", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
